// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - IF->ID handshake and payload bundle
interface if_id_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_ready;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc_plus4;
  logic            id_misalign;

  // master: fetch/decode environment around the stage
  modport master (
    output if_valid, if_pc, if_instr, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_pc_plus4, id_misalign
  );

  // slave: the pipeline stage itself
  modport slave (
    input  if_valid, if_pc, if_instr, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_pc_plus4, id_misalign
  );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF->ID 2-entry skid buffer with flush, NOP bubble, pc+4, misalign tag
module if_id_stage #(
  parameter int          XLEN  = 32,
  parameter logic [31:0] NOP   = 32'h0000_0013,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  if_id_stage_if.slave     bus,
  input  logic             flush,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [XLEN-1:0] pc_mem    [2];
  logic [XLEN-1:0] instr_mem [2];
  logic            mis_mem   [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic            flush_hit;

  assign bus.if_ready = (count != 2'd2);
  assign bus.id_valid = (count != 2'd0);

  assign push      = bus.if_valid & bus.if_ready & ~flush;
  assign pop       = bus.id_valid & bus.id_ready & ~flush;
  assign flush_hit = flush & ((count != 2'd0) | bus.if_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      flush_cnt <= '0;
    end else begin
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
      if (flush_hit && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Payload storage needs no reset: count=0 masks it on the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= bus.if_pc;
      instr_mem[wr_ptr] <= bus.if_instr;
      mis_mem[wr_ptr]   <= (bus.if_pc[1:0] != 2'b00);
    end
  end

  assign bus.id_pc       = bus.id_valid ? pc_mem[rd_ptr] : '0;
  assign bus.id_instr    = bus.id_valid ? instr_mem[rd_ptr] : XLEN'(NOP);
  assign bus.id_misalign = bus.id_valid & mis_mem[rd_ptr];
  assign bus.id_pc_plus4 = bus.id_pc + XLEN'(4);
endmodule
